waveform_buffer: RTL



---
 rtl/waveform_buffer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/waveform_buffer.sv
// waveform_buffer: circular ECG sample store with a per-frame snapshot feeding the waveform renderer.
// Optional WAVEBUF_PEAK_EN stores the maximum of each decimation group instead of its last sample.
module waveform_buffer #(
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DECIM  = 4,
   parameter logic [7:0]  BLANK  = 8'd128
) (
   input  logic              clk_65mhz,
   input  logic              reset,
   input  logic [7:0]        sample_in,
   input  logic              sample_valid,
   input  logic              pause,
   input  logic              clear,
   input  logic              frame_start,
   input  logic [10:0]       signal_pix,
   output logic [7:0]        signal_out,
   output logic [ADDR_W:0]   fill_count,
   output logic              busy,
   output logic              sample_dropped
);

   typedef enum logic {StSweep, StRun} state_e;

   localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   FullCount = (ADDR_W + 1)'(DEPTH);
   localparam logic [7:0]        LastDecim = 8'(DECIM - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] sweep_addr_q, sweep_addr_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [7:0]        decim_cnt_q, decim_cnt_d;
   logic [ADDR_W:0]   fill_q, fill_d;
   logic [ADDR_W-1:0] snap_ptr_q, snap_ptr_d;
   logic              snap_full_q, snap_full_d;
   logic              dropped_q, dropped_d;
   logic              blank_q, blank_d;
   logic [7:0]        rd_data_q;
   logic [7:0]        mem [DEPTH];

   logic              accept, store, mem_we, pix_oob;
   logic [ADDR_W-1:0] mem_waddr, rd_addr, pix_lo;
   logic [7:0]        mem_wdata, store_data;

   assign accept = (state_q == StRun) && sample_valid && !pause && !clear;
   assign store  = accept && (decim_cnt_q == LastDecim);

`ifdef WAVEBUF_PEAK_EN
   logic [7:0] max_q, max_d;

   // The first sample of a group ignores max_q, so a group restarts from that sample.
   always_comb begin
      store_data = sample_in;
      if ((decim_cnt_q != '0) && (max_q > sample_in)) store_data = max_q;
   end

   always_comb begin
      max_d = max_q;
      if (clear)       max_d = '0;
      else if (accept) max_d = store ? 8'd0 : store_data;
   end

   always_ff @(posedge clk_65mhz or posedge reset) begin
      if (reset) max_q <= '0;
      else       max_q <= max_d;
   end
`else
   assign store_data = sample_in;
`endif

   // Column lookup against the frozen snapshot so a whole frame sees one history.
   assign pix_lo  = signal_pix[ADDR_W-1:0];
   assign pix_oob = 32'(signal_pix) >= DEPTH;
   assign rd_addr = snap_full_q ? (snap_ptr_q + pix_lo) : pix_lo;
   assign blank_d = (state_q == StSweep) || pix_oob || (!snap_full_q && (pix_lo >= snap_ptr_q));

   assign mem_we    = (state_q == StSweep) || store;
   assign mem_waddr = (state_q == StSweep) ? sweep_addr_q : wr_ptr_q;
   assign mem_wdata = (state_q == StSweep) ? BLANK : store_data;

   always_ff @(posedge clk_65mhz) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      rd_data_q <= mem[rd_addr];
   end

   always_comb begin
      state_d      = state_q;
      sweep_addr_d = sweep_addr_q;
      wr_ptr_d     = wr_ptr_q;
      decim_cnt_d  = decim_cnt_q;
      fill_d       = fill_q;
      snap_ptr_d   = snap_ptr_q;
      snap_full_d  = snap_full_q;
      dropped_d    = dropped_q;

      if (frame_start) begin
         snap_ptr_d  = wr_ptr_q;
         snap_full_d = (fill_q == FullCount);
      end

      unique case (state_q)
         StSweep: begin
            if (sample_valid) dropped_d = 1'b1;
            if (clear)                          sweep_addr_d = '0;
            else if (sweep_addr_q == LastAddr)  state_d = StRun;
            else                                sweep_addr_d = sweep_addr_q + 1'b1;
         end
         StRun: begin
            if (clear) begin
               state_d      = StSweep;
               sweep_addr_d = '0;
               wr_ptr_d     = '0;
               decim_cnt_d  = '0;
               fill_d       = '0;
               dropped_d    = 1'b0;
               if (frame_start) begin
                  snap_ptr_d  = '0;
                  snap_full_d = 1'b0;
               end
            end else if (store) begin
               wr_ptr_d    = wr_ptr_q + 1'b1;
               decim_cnt_d = '0;
               if (fill_q != FullCount) fill_d = fill_q + 1'b1;
            end else if (accept) begin
               decim_cnt_d = decim_cnt_q + 1'b1;
            end
         end
         default: state_d = StSweep;
      endcase
   end

   always_ff @(posedge clk_65mhz or posedge reset) begin
      if (reset) begin
         state_q      <= StSweep;
         sweep_addr_q <= '0;
         wr_ptr_q     <= '0;
         decim_cnt_q  <= '0;
         fill_q       <= '0;
         snap_ptr_q   <= '0;
         snap_full_q  <= 1'b0;
         dropped_q    <= 1'b0;
         blank_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         sweep_addr_q <= sweep_addr_d;
         wr_ptr_q     <= wr_ptr_d;
         decim_cnt_q  <= decim_cnt_d;
         fill_q       <= fill_d;
         snap_ptr_q   <= snap_ptr_d;
         snap_full_q  <= snap_full_d;
         dropped_q    <= dropped_d;
         blank_q      <= blank_d;
      end
   end

   assign signal_out     = blank_q ? BLANK : rd_data_q;
   assign fill_count     = fill_q;
   assign busy           = (state_q == StSweep);
   assign sample_dropped = dropped_q;

endmodule
